// File: rtl/lsu_controller.sv
// Load/store sequencer: one req/ack data-bus transaction per memory instruction.
// Define LSU_TIMEOUT_EN to abort a bus wait after p_TimeoutCycles cycles without ack.
//   state | meaning
//   IDLE  | waiting for a memory instruction
//   BUS   | o_BusReq held until ack (or timeout)
//   DONE  | one-cycle writeback / stall release
module lsu_controller #(
    parameter int p_TimeoutCycles = 255
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_DBusRe,
    input  logic        i_DBusWe,
    input  logic [2:0]  i_Func3,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WData,
    input  logic [4:0]  i_Rd,
    output logic        o_Stall,
    output logic        o_BusReq,
    output logic        o_BusWe,
    output logic [31:0] o_BusAddr,
    output logic [3:0]  o_BusByteEn,
    output logic [31:0] o_BusWData,
    input  logic        i_BusAck,
    input  logic [31:0] i_BusRData,
    output logic        o_LoadValid,
    output logic [31:0] o_LoadData,
    output logic [4:0]  o_LoadRd,
    output logic        o_AccessErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  func3_q;
    logic [1:0]  addr_lo;
    logic [4:0]  rd_q;

    logic        req;
    logic        is_load;
    logic        func3_ok;
    logic        align_ok;
    logic        accept;
    logic        reject;
    logic        tmo_hit;
    logic [3:0]  byteen_next;
    logic [31:0] wdata_next;
    logic [31:0] rdata_shift;
    logic [31:0] load_result;

    if (p_TimeoutCycles < 1) begin : g_param_check
        $error("p_TimeoutCycles must be at least 1");
    end

    // A simultaneous read and write strobe is handled as a store.
    assign req     = i_DBusRe | i_DBusWe;
    assign is_load = i_DBusRe & ~i_DBusWe;

    always_comb begin
        func3_ok = 1'b0;
        case (i_Func3)
            3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
            3'b100, 3'b101:         func3_ok = is_load;
            default:                func3_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b1;
        case (i_Func3[1:0])
            2'b01:   align_ok = ~i_Addr[0];
            2'b10:   align_ok = (i_Addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign accept  = (state == IDLE) & req & func3_ok & align_ok;
    assign reject  = (state == IDLE) & req & ~(func3_ok & align_ok);
    assign o_Stall = (state == BUS) | accept;

    always_comb begin
        byteen_next = 4'b1111;
        wdata_next  = i_WData;
        case (i_Func3[1:0])
            2'b00: begin
                byteen_next = 4'b0001 << i_Addr[1:0];
                wdata_next  = {4{i_WData[7:0]}};
            end
            2'b01: begin
                byteen_next = 4'b0011 << i_Addr[1:0];
                wdata_next  = {2{i_WData[15:0]}};
            end
            default: begin
                byteen_next = 4'b1111;
                wdata_next  = i_WData;
            end
        endcase
    end

    // Shifting the word down by the byte offset puts the addressed byte/half at bit 0.
    assign rdata_shift = i_BusRData >> {addr_lo, 3'b000};

    always_comb begin
        load_result = rdata_shift;
        case (func3_q[1:0])
            2'b00:   load_result = {{24{rdata_shift[7] & ~func3_q[2]}}, rdata_shift[7:0]};
            2'b01:   load_result = {{16{rdata_shift[15] & ~func3_q[2]}}, rdata_shift[15:0]};
            default: load_result = rdata_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_CntW = $clog2(p_TimeoutCycles + 1);
    localparam logic [c_CntW-1:0] c_CntLast = c_CntW'(p_TimeoutCycles - 1);

    logic [c_CntW-1:0] tmo_cnt;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tmo_cnt <= '0;
        end else if (state != BUS) begin
            tmo_cnt <= '0;
        end else if (!i_BusAck) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == c_CntLast);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            func3_q     <= 3'b000;
            addr_lo     <= 2'b00;
            rd_q        <= 5'd0;
            o_BusReq    <= 1'b0;
            o_BusWe     <= 1'b0;
            o_BusAddr   <= 32'd0;
            o_BusByteEn <= 4'd0;
            o_BusWData  <= 32'd0;
            o_LoadValid <= 1'b0;
            o_LoadData  <= 32'd0;
            o_LoadRd    <= 5'd0;
            o_AccessErr <= 1'b0;
        end else begin
            o_LoadValid <= 1'b0;
            o_AccessErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= BUS;
                        o_BusReq    <= 1'b1;
                        o_BusWe     <= i_DBusWe;
                        o_BusAddr   <= {i_Addr[31:2], 2'b00};
                        o_BusByteEn <= byteen_next;
                        o_BusWData  <= wdata_next;
                        func3_q     <= i_Func3;
                        addr_lo     <= i_Addr[1:0];
                        rd_q        <= i_Rd;
                    end else if (reject) begin
                        o_AccessErr <= 1'b1;
                    end
                end
                BUS: begin
                    if (i_BusAck) begin
                        state    <= DONE;
                        o_BusReq <= 1'b0;
                        if (!o_BusWe) begin
                            o_LoadValid <= 1'b1;
                            o_LoadData  <= load_result;
                            o_LoadRd    <= rd_q;
                        end
                    end else if (tmo_hit) begin
                        state       <= DONE;
                        o_BusReq    <= 1'b0;
                        o_AccessErr <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller; timeout cases are built in
// only when LSU_TIMEOUT_EN is defined (bench uses p_TimeoutCycles = 4).
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbus_re, dbus_we;
    logic [2:0]  func3;
    logic [31:0] addr_in, wdata_in;
    logic [4:0]  rd_in;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        access_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_controller #(.p_TimeoutCycles(4)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_DBusRe    (dbus_re),
        .i_DBusWe    (dbus_we),
        .i_Func3     (func3),
        .i_Addr      (addr_in),
        .i_WData     (wdata_in),
        .i_Rd        (rd_in),
        .o_Stall     (stall),
        .o_BusReq    (bus_req),
        .o_BusWe     (bus_we),
        .o_BusAddr   (bus_addr),
        .o_BusByteEn (bus_be),
        .o_BusWData  (bus_wdata),
        .i_BusAck    (bus_ack),
        .i_BusRData  (bus_rdata),
        .o_LoadValid (load_valid),
        .o_LoadData  (load_data),
        .o_LoadRd    (load_rd),
        .o_AccessErr (access_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        dbus_re  = re;
        dbus_we  = we;
        func3    = f3;
        addr_in  = a;
        wdata_in = wd;
        rd_in    = rd;
    endtask

    // Legal access: ack in BUS cycle ack_at; request held until the pipeline advances.
    task automatic mem_op(input string tag, input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int ack_at, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_ld);
        @(posedge clk); #1;
        drive(re, we, f3, a, wd, rd);
        @(negedge clk);
        check({tag, " accept stall"}, stall, 1'b1);
        check({tag, " accept req"}, bus_req, 1'b0);
        for (int c = 1; c <= ack_at; c++) begin
            @(posedge clk); #1;
            if (c == ack_at) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            @(negedge clk);
            check({tag, " bus req"}, bus_req, 1'b1);
            check({tag, " bus stall"}, stall, 1'b1);
            if (c == 1) begin
                check({tag, " bus addr"}, bus_addr, {a[31:2], 2'b00});
                check({tag, " byteen"}, bus_be, exp_be);
                check({tag, " bus we"}, bus_we, we);
                if (we) check({tag, " wdata"}, bus_wdata, exp_wd);
            end
        end
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        @(negedge clk);
        check({tag, " done stall"}, stall, 1'b0);
        check({tag, " done req"}, bus_req, 1'b0);
        check({tag, " done err"}, access_err, 1'b0);
        check({tag, " done valid"}, load_valid, !we);
        if (!we) begin
            check({tag, " load data"}, load_data, exp_ld);
            check({tag, " load rd"}, load_rd, rd);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check({tag, " valid pulse"}, load_valid, 1'b0);
        if (!we) check({tag, " data hold"}, load_data, exp_ld);
    endtask

    task automatic bad_op(input string tag, input logic re, input logic we,
                          input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        drive(re, we, f3, a, 32'h0, 5'd3);
        @(negedge clk);
        check({tag, " stall"}, stall, 1'b0);
        check({tag, " req"}, bus_req, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check({tag, " err"}, access_err, 1'b1);
        check({tag, " req after"}, bus_req, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " err pulse"}, access_err, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #1;
        check("reset req", bus_req, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset valid", load_valid, 1'b0);
        check("reset err", access_err, 1'b0);
        check("reset data", load_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mem_op("lb",  1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 1,
               32'h80AA_55CC, 4'b1000, 32'h0, 32'hFFFF_FF80);
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd6, 1,
               32'h8001_FFFF, 4'b1100, 32'h0, 32'h0000_8001);
        mem_op("lh",  1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd7, 1,
               32'h8001_FFFF, 4'b1100, 32'h0, 32'hFFFF_8001);
        mem_op("sh",  1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 5'd0, 3,
               32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        check("sh keeps load data", load_data, 32'hFFFF_8001);
        check("sh keeps load rd", load_rd, 5'd7);
        mem_op("sb re+we", 1'b1, 1'b1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 5'd0, 1,
               32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        mem_op("sw",  1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 5'd0, 2,
               32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_6002, 32'h0, 5'd8, 1,
               32'h11F2_3344, 4'b0100, 32'h0, 32'h0000_00F2);
        mem_op("lw",  1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd31, 2,
               32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

        bad_op("lw misaligned", 1'b1, 1'b0, 3'b010, 32'h0000_0101);
        bad_op("func3 011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        bad_op("store func3 100", 1'b0, 1'b1, 3'b100, 32'h0000_0000);
        bad_op("lh misaligned", 1'b1, 1'b0, 3'b001, 32'h0000_0001);

        // Reset while the bus request is outstanding.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd9);
        @(posedge clk); #1;
        check("pre-reset req", bus_req, 1'b1);
        #2;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        #1;
        check("async reset req", bus_req, 1'b0);
        check("async reset stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_5555;
        @(negedge clk);
        check("stray ack req", bus_req, 1'b0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("stray ack valid", load_valid, 1'b0);
        check("stray ack stall", stall, 1'b0);
        mem_op("lw after reset", 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd10, 1,
               32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd11);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("timeout bus req", bus_req, 1'b1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout req drop", bus_req, 1'b0);
        check("timeout err", access_err, 1'b1);
        check("timeout valid", load_valid, 1'b0);
        check("timeout stall", stall, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("timeout err pulse", access_err, 1'b0);
        mem_op("ack on timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd12, 4,
               32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
Load/store sequencer between the execute stage and the shared data bus. Takes the decoded data-bus read/write strobes, func3, ALU address, rs2 data and rd. Runs one bus transaction per memory instruction with a req/ack handshake, stalling the pipeline until it completes. Generates byte enables and store-data lane replication, and aligns and sign- or zero-extends load data for writeback.

Parameters:
p_TimeoutCycles, 255, bus-wait cycles before abort (used only with LSU_TIMEOUT_EN); counter width is $clog2(p_TimeoutCycles+1)

Ports:
i_Clk  input  1  clock, rising edge
i_Rst  input  1  reset, asynchronous, active-high
i_DBusRe  input  1  load request from decoder control
i_DBusWe  input  1  store request from decoder control
i_Func3  input  3  access size/sign (RV32I load/store func3)
i_Addr  input  32  effective byte address (ALU result)
i_WData  input  32  store data (rs2)
i_Rd  input  5  load destination register
o_Stall  output  1  hold pipeline
o_BusReq  output  1  bus request, held until ack
o_BusWe  output  1  1 = write transaction
o_BusAddr  output  32  word address, {addr[31:2],2'b00}
o_BusByteEn  output  4  active byte lanes
o_BusWData  output  32  lane-replicated store data
i_BusAck  input  1  bus completion; read data valid same cycle
i_BusRData  input  32  bus read word
o_LoadValid  output  1  one-cycle writeback strobe
o_LoadData  output  32  aligned, extended load result
o_LoadRd  output  5  destination for o_LoadData
o_AccessErr  output  1  one-cycle pulse: misaligned or illegal func3

Behaviour:
- Reset (async, any state): state IDLE. All registered outputs 0. o_BusReq drops immediately and any in-flight transaction is abandoned.
- States: IDLE, BUS, DONE.
- IDLE with no request: outputs idle, o_Stall=0.
- IDLE, request present and legal:
  - o_Stall=1 combinationally in the same cycle.
  - Latch addr, func3, wdata, rd and the we flag; go to BUS.
- If i_DBusRe and i_DBusWe are both high, treat the access as a store.
- Legality:
  - func3 000, 001 and 010 are legal for both loads and stores.
  - func3 100 and 101 are legal for loads only.
  - All other func3 values are illegal.
  - Halfword accesses require addr[0]=0; word accesses require addr[1:0]=0.
- Illegal access in IDLE: o_AccessErr pulses next cycle, no bus activity, o_Stall=0. The instruction retires as a NOP and the state stays IDLE.
- BUS state:
  - o_BusReq=1; addr, we, byteen and wdata are registered and stable until ack.
  - o_Stall=1.
  - On i_BusAck=1, capture load data and go to DONE.
- i_BusAck outside BUS is ignored.
- DONE (exactly one cycle):
  - o_Stall=0; o_BusReq=0.
  - For loads, o_LoadValid=1 with o_LoadData and o_LoadRd.
  - Request inputs are ignored, since the completed instruction advances on this edge.
  - Always returns to IDLE.
- Latency: request seen in cycle 0, o_BusReq from cycle 1, ack in cycle k≥1, o_LoadValid and stall release in cycle k+1.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - The same enables are driven for reads.
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load data:
  - Select the byte rdata[8*addr[1:0]+:8] or the half rdata[16*addr[1]+:16].
  - Sign-extend for func3 000 and 001; zero-extend for 100 and 101.
  - o_LoadData and o_LoadRd hold their value until the next load completes.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle after DONE, so there is at least one non-bus cycle between transactions.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches p_TimeoutCycles:
  - o_BusReq drops and the state goes to DONE.
  - o_AccessErr pulses in DONE and o_LoadValid stays 0.
  - An ack arriving on the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter; BUS waits indefinitely for ack.

Test Plan:
- LB at 0x1003, ack after 1 cycle with rdata 0x80AA55CC -> o_BusAddr 0x1000, ByteEn 4'b1000, o_LoadData 0xFFFFFF80; LoadValid one cycle in the cycle after ack.
- LHU at 0x2002, rdata 0x8001FFFF -> LoadData 0x00008001; LH at the same address -> 0xFFFF8001.
- SH at 0x3002, wdata 0x1234ABCD, ack delayed 3 cycles -> BusWe=1, ByteEn 4'b1100, WData 0xABCDABCD; BusReq and Stall high for 3 BUS cycles (plus stall in the accept cycle); Stall low in DONE; no LoadValid.
- LW at 0x0101, and func3 3'b011 at 0x0100 -> AccessErr one pulse each, BusReq never asserted, Stall stays 0.
- i_Rst asserted mid-BUS -> BusReq and Stall drop asynchronously. A later i_BusAck is ignored; a new LW at 0x40 after reset completes normally.
- With LSU_TIMEOUT_EN and p_TimeoutCycles=4, withhold ack -> BusReq drops after 4 BUS cycles, AccessErr pulses, LoadValid stays 0.
- Same configuration with ack on cycle 4 -> normal completion, no AccessErr.
